la_rle_unpacker: RTL and testbench

//  Downstream consumer of the logic-analyzer AXI-Stream output. Accepts run-length packets
//  {rc[7:0], sample[23:0]} and re-expands each packet into rc consecutive per-clock samples
//  on a valid/ready sample port. Keeps sample/packet/error statistics for capture

---
 rtl/la_rle_unpacker_if.sv | 26 ++
 rtl/la_rle_unpacker.sv | 111 +++++++++++
 tb/tb_la_rle_unpacker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/la_rle_unpacker_if.sv
// rtl/la_rle_unpacker_if.sv - packet stream in, expanded sample stream out
interface la_rle_unpacker_if #(
    parameter int pDATA_WIDTH   = 32,
    parameter int pSAMPLE_WIDTH = 24
);
    logic [pDATA_WIDTH-1:0]   s_tdata;
    logic                     s_tvalid;
    logic                     s_tlast;
    logic [1:0]               s_tuser;
    logic                     s_tready;
    logic [pSAMPLE_WIDTH-1:0] out_data;
    logic [1:0]               out_user;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, s_tuser, out_ready,
        output s_tready, out_data, out_user, out_valid, out_last
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, s_tuser, out_ready,
        input  s_tready, out_data, out_user, out_valid, out_last
    );
endinterface

// File: rtl/la_rle_unpacker.sv
// rtl/la_rle_unpacker.sv - expands {rc, sample} run-length packets into per-clock samples
module la_rle_unpacker #(
    parameter int pDATA_WIDTH   = 32,
    parameter int pSAMPLE_WIDTH = 24,
    parameter int pCNT_WIDTH    = 8
) (
    input  logic                axis_clk,
    input  logic                axis_rst_n,
    input  logic                unpack_en,
    input  logic                stat_clr,
    la_rle_unpacker_if.slave    bus,
    output logic [31:0]         sample_cnt,
    output logic [15:0]         pkt_cnt,
    output logic                err_zero_rc
);
    typedef enum logic {EMPTY, EXPAND} state_t;

    state_t                   state_q, state_d;
    logic [pCNT_WIDTH-1:0]    rem_q, rem_d;
    logic [pSAMPLE_WIDTH-1:0] data_q, data_d;
    logic [1:0]               user_q, user_d;
    logic                     last_q, last_d;
    logic                     pkt_last_q, pkt_last_d;
    logic [31:0]              sample_cnt_q, sample_cnt_d;
    logic [15:0]              pkt_cnt_q, pkt_cnt_d;
    logic                     err_q, err_d;

    logic [pCNT_WIDTH-1:0]    rc;
    logic                     out_valid, rem_is_one, ready, accept, out_hs;

    assign rc         = bus.s_tdata[pDATA_WIDTH-1 -: pCNT_WIDTH];
    assign out_valid  = (state_q == EXPAND);
    assign rem_is_one = (rem_q == pCNT_WIDTH'(1));
    assign ready      = unpack_en && (!out_valid || (bus.out_ready && rem_is_one));
    assign accept     = bus.s_tvalid && ready;
    assign out_hs     = out_valid && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        data_d       = data_q;
        user_d       = user_q;
        last_d       = last_q;
        pkt_last_d   = pkt_last_q;
        sample_cnt_d = sample_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        err_d        = err_q;

        if (out_hs && !rem_is_one) begin
            rem_d  = rem_q - pCNT_WIDTH'(1);
            last_d = pkt_last_q && (rem_q == pCNT_WIDTH'(2));
        end else if (!out_valid || out_hs) begin
            // Either idle or showing the final sample: a new packet may take its place.
            if (accept && rc != '0) begin
                state_d    = EXPAND;
                rem_d      = rc;
                data_d     = bus.s_tdata[pSAMPLE_WIDTH-1:0];
                user_d     = bus.s_tuser;
                pkt_last_d = bus.s_tlast;
                last_d     = bus.s_tlast && (rc == pCNT_WIDTH'(1));
            end else if (out_hs || accept) begin
                state_d = EMPTY;
                rem_d   = '0;
                last_d  = 1'b0;
            end
        end

        if (stat_clr) begin
            sample_cnt_d = '0;
            pkt_cnt_d    = '0;
            err_d        = 1'b0;
        end else begin
            if (out_hs && sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + 32'd1;
            if (accept)                       pkt_cnt_d    = pkt_cnt_q + 16'd1;
            if (accept && rc == '0)           err_d        = 1'b1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q      <= EMPTY;
            rem_q        <= '0;
            data_q       <= '0;
            user_q       <= '0;
            last_q       <= 1'b0;
            pkt_last_q   <= 1'b0;
            sample_cnt_q <= '0;
            pkt_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            data_q       <= data_d;
            user_q       <= user_d;
            last_q       <= last_d;
            pkt_last_q   <= pkt_last_d;
            sample_cnt_q <= sample_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_q        <= err_d;
        end
    end

    assign bus.s_tready  = ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.out_user  = user_q;
    assign bus.out_last  = last_q;
    assign sample_cnt    = sample_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_zero_rc   = err_q;
endmodule

// File: tb/tb_la_rle_unpacker.sv
// tb/tb_la_rle_unpacker.sv - directed and randomized checks against a sample-queue reference model
module tb_la_rle_unpacker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [31:0] sample_cnt;
    logic [15:0] pkt_cnt;
    logic        err_zero_rc;

    la_rle_unpacker_if #(.pDATA_WIDTH(32), .pSAMPLE_WIDTH(24)) bus ();

    la_rle_unpacker #(.pDATA_WIDTH(32), .pSAMPLE_WIDTH(24), .pCNT_WIDTH(8)) dut (
        .axis_clk    (clk),
        .axis_rst_n  (rst_n),
        .unpack_en   (en),
        .stat_clr    (clr),
        .bus         (bus),
        .sample_cnt  (sample_cnt),
        .pkt_cnt     (pkt_cnt),
        .err_zero_rc (err_zero_rc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic [1:0]  user;
        logic        last;
    } smp_t;

    smp_t        q[$];
    logic [31:0] m_samples;
    logic [15:0] m_pkts;
    logic        m_err;
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    logic        acc_m;
    logic        exp_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic hs;
        logic [7:0] rc;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        exp_rdy = en && (q.size() == 0 || (bus.out_ready && q.size() == 1));
        chk("s_tready", bus.s_tready, exp_rdy);
        chk("out_valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", bus.out_data, q[0].data);
            chk("out_user", bus.out_user, q[0].user);
            chk("out_last", bus.out_last, q[0].last);
        end
        chk("sample_cnt", sample_cnt, m_samples);
        chk("pkt_cnt", pkt_cnt, m_pkts);
        chk("err_zero_rc", err_zero_rc, m_err);
        hs    = (q.size() != 0) && bus.out_ready;
        acc_m = bus.s_tvalid && exp_rdy;
        rc    = bus.s_tdata[31:24];
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_samples = 0;
            m_pkts    = 0;
            m_err     = 0;
            acc_m     = 0;
        end else begin
            if (hs) void'(q.pop_front());
            if (acc_m) begin
                for (int k = 0; k < rc; k++)
                    q.push_back('{bus.s_tdata[23:0], bus.s_tuser, bus.s_tlast && (k == rc - 1)});
            end
            if (clr) begin
                m_samples = 0;
                m_pkts    = 0;
                m_err     = 0;
            end else begin
                if (hs && m_samples != 32'hFFFF_FFFF) m_samples++;
                if (acc_m) m_pkts++;
                if (acc_m && rc == 0) m_err = 1;
            end
        end
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] user);
        int n = 0;
        bus.s_tdata  = d;
        bus.s_tlast  = last;
        bus.s_tuser  = user;
        bus.s_tvalid = 1'b1;
        do begin
            step();
            n++;
        end while (!acc_m && n < 600);
        chk("send_timeout", n < 600, 1'b1);
        bus.s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 1000, 1'b1);
        step();
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 0; en = 0; clr = 0;
        bus.s_tdata = '0; bus.s_tvalid = 0; bus.s_tlast = 0; bus.s_tuser = '0; bus.out_ready = 1;
        m_samples = 0; m_pkts = 0; m_err = 0; acc_m = 0;
        @(posedge clk);
        #1;

        // Reset held with unpack_en low, then unpack_en raised
        for (int i = 0; i < 10; i++) step();
        chk("rst_out_data", bus.out_data, 24'h0);
        en = 1;
        step();
        rst_n = 1;
        step();

        // Single rc=3 packet
        send(32'h03ABCDEF, 1'b0, 2'd1);
        drain();
        chk("t2_samples", sample_cnt, 32'd3);
        chk("t2_pkts", pkt_cnt, 16'd1);

        // 200 back-to-back rc=1 packets
        clear_stats();
        for (int i = 0; i < 200; i++) send({8'h01, 24'(i)}, 1'b0, 2'(i));
        drain();
        chk("t3_samples", sample_cnt, 32'd200);

        // rc=255 with tlast under toggling backpressure
        clear_stats();
        rdy_mode = 1;
        send(32'hFF000055, 1'b1, 2'd2);
        drain();
        chk("t4_samples", sample_cnt, 32'd255);
        rdy_mode = 0;

        // Zero-rc packet between two rc=2 packets, then clear
        clear_stats();
        send(32'h02000001, 1'b0, 2'd0);
        send(32'h00123456, 1'b0, 2'd0);
        send(32'h02000002, 1'b1, 2'd3);
        drain();
        chk("t5_samples", sample_cnt, 32'd4);
        chk("t5_pkts", pkt_cnt, 16'd3);
        chk("t5_err", err_zero_rc, 1'b1);
        clear_stats();
        chk("t5_clr_samples", sample_cnt, 32'd0);
        chk("t5_clr_err", err_zero_rc, 1'b0);

        // Reset during the second sample of an rc=5 packet
        send(32'h05000777, 1'b0, 2'd1);
        n = 0;
        while (q.size() != 4 && n < 20) begin step(); n++; end
        chk("t6_reach", q.size(), 32'd4);
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        chk("t6_valid", bus.out_valid, 1'b0);
        send(32'h03000999, 1'b1, 2'd2);
        drain();

        // unpack_en dropped mid-packet with another packet waiting
        send(32'h04000077, 1'b0, 2'd0);
        en = 0;
        bus.s_tdata = 32'h02000088; bus.s_tvalid = 1;
        for (int i = 0; i < 8; i++) step();
        chk("en_drop_idle", bus.out_valid, 1'b0);
        en = 1;
        send(32'h02000088, 1'b1, 2'd1);
        drain();

        // Randomized traffic with random backpressure and occasional enable drops
        rdy_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.s_tvalid) begin
                bus.s_tvalid = 1'($urandom_range(0, 3) != 0);
                bus.s_tdata  = {8'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 6)), 24'($urandom)};
                bus.s_tlast  = 1'($urandom_range(0, 1));
                bus.s_tuser  = 2'($urandom_range(0, 3));
            end
            en  = ($urandom_range(0, 19) != 0);
            clr = ($urandom_range(0, 199) == 0);
            step();
            if (acc_m) bus.s_tvalid = 1'b0;
        end
        bus.s_tvalid = 0; en = 1; clr = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
